serial_tx: RTL
==============

SERIAL_TX -- requirements
Module: serial_tx

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the payload bits per frame (legal range 1..16).
REQ-002 Parameter CLKS_PER_BIT, default 4, SHALL set the clk cycles each serial bit is held (legal range 1..65535).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  SHALL be the asynchronous active-low reset.
REQ-006 tx_data  input  DATA_W  SHALL carry the parallel word to send, sampled only at acceptance.
REQ-007 tx_valid  input  1  SHALL be asserted high when tx_data holds a word to send.
REQ-008 tx_ready  output  1  SHALL be high when the block can accept a word.
REQ-009 tx  output  1  SHALL be the serial line: idle high, LSB first.
REQ-010 busy  output  1  SHALL be high whenever a frame is in progress.

Function
REQ-011 Acceptance SHALL occur on a rising edge where tx_valid=1 and tx_ready=1; tx_data SHALL be latched into an internal shift register on that edge.
REQ-012 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; acceptance SHALL move IDLE->START.
REQ-013 In IDLE: tx=1, tx_ready=1, busy=0; in all other states: tx_ready=0, busy=1.
REQ-014 tx SHALL go low on the acceptance edge (zero-cycle latency) and each bit SHALL be held exactly CLKS_PER_BIT cycles.
REQ-015 Bit order SHALL be start (0), DATA_W data bits LSB first, optional parity bit, stop (1).
REQ-016 Transitions: START->DATA after one bit time; DATA->PARITY (or STOP when parity is compiled out) after DATA_W bit times; PARITY->STOP after one bit time; STOP->IDLE after one bit time.
REQ-017 Frame length SHALL be (DATA_W+2+P)*CLKS_PER_BIT cycles, with P=1 when parity is compiled in and 0 otherwise.
REQ-018 tx_valid and tx_data changes while busy=1 SHALL be ignored and SHALL not affect the frame in flight.
REQ-019 With tx_valid held high continuously, consecutive frames SHALL be separated by exactly one IDLE cycle with tx=1.
REQ-020 With CLKS_PER_BIT=1, each bit SHALL last one cycle with no change to the state order.
REQ-021 The bit-time counter SHALL be wide enough for CLKS_PER_BIT-1 and SHALL reload to 0 on every bit boundary; it SHALL never wrap mid-bit.

Reset
REQ-022 While rst_n=0: tx=1, tx_ready=0, busy=0, FSM=IDLE, counters and shift register 0.
REQ-023 After rst_n rises: tx_ready=1 from the first rising clk edge.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately; tx=1 with no partial-bit glitch low.

Configuration
REQ-025 Macro SERIAL_TX_PARITY_EN defined: the PARITY state SHALL be present and SHALL send even parity (XOR of all latched data bits).
REQ-026 Macro SERIAL_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, and DATA SHALL go directly to STOP.

Structure
REQ-027 Shared package serial_pkg SHALL hold the state enumeration (IDLE, START, DATA, PARITY, STOP), the idle/start/stop line-level constants and the default DATA_W/CLKS_PER_BIT values.
REQ-028 Sub-module bit_timer SHALL generate a one-cycle bit_done pulse every CLKS_PER_BIT cycles; it SHALL be cleared when serial_tx is in IDLE.

Verification
REQ-029 DATA_W=8, CLKS_PER_BIT=4, no parity, send 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles total), then tx_ready=1.
REQ-030 SERIAL_TX_PARITY_EN defined, send 0xA5 then 0x01 -> parity bits 0 then 1; each frame 44 cycles.
REQ-031 tx_valid held high, words 0x3C and 0xC3 -> two back-to-back frames separated by exactly one idle cycle with tx=1.
REQ-032 Drive tx_data=0xFF with tx_valid=1 during a frame of 0x00 -> line carries 0x00 only; 0xFF is accepted only after tx_ready returns high.
REQ-033 rst_n pulsed low during data bit 3 -> tx=1 and busy=0 immediately; the next accepted word produces a clean full frame.
REQ-034 CLKS_PER_BIT=1, send 0x80 -> tx = 0,0,0,0,0,0,0,0,1,1 on 10 consecutive cycles.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmitter.
// The PARITY state exists only when SERIAL_TX_PARITY_EN is defined.
package serial_pkg;

  localparam int DEF_DATA_W       = 8;
  localparam int DEF_CLKS_PER_BIT = 4;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef SERIAL_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

  // Counter width that also works for a terminal value of 0 (value 1).
  function automatic int clog2_min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/serial_tx_bit_timer.sv
// Bit-time counter: bit_done pulses on the last cycle of every CLKS_PER_BIT-cycle bit.
// Held at zero while clear is high, so each frame starts on a fresh bit boundary.
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_done
);

  localparam int            CW   = clog2_min1(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    bit_done = 1'b0;
    cnt_d    = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      bit_done = 1'b1;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start, DATA_W bits LSB first, optional even parity (SERIAL_TX_PARITY_EN), stop.
// tx drops on the acceptance edge; tx_ready is low for the whole frame, so new words wait.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy
);

  localparam int            BW       = clog2_min1(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [BW-1:0]     bit_idx_q, bit_idx_d;
  logic              init_q, init_d;
  logic              bit_done;
  logic              accept;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (state_q == IDLE),
    .bit_done(bit_done)
  );

  // tx_ready stays low during reset and rises one edge after release.
  assign tx_ready = (state_q == IDLE) && init_q;
  assign busy     = (state_q != IDLE);
  assign accept   = tx_valid && tx_ready;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    init_d    = 1'b1;
    tx        = LINE_IDLE;
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = tx_data;
          bit_idx_d = '0;
`ifdef SERIAL_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end
      START: begin
        tx = LINE_START;
        if (bit_done) state_d = DATA;
      end
      DATA: begin
        tx = shift_q[0];
        if (bit_done) begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + BW'(1);
          if (bit_idx_q == LAST_BIT) begin
`ifdef SERIAL_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: begin
        tx = parity_q;
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        tx = LINE_STOP;
        if (bit_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      init_q    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      init_q    <= init_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule
